neuron_sad_integrator: RTL and testbench
========================================

// Module: neuron_sad_integrator
// PURPOSE
//  Leaky integrate-and-fire stage directly downstream of the 8-bit Sklansky adder.
//  It consumes each registered 8-bit adder sum as one input sample and accumulates
//  the samples into a saturating membrane register. When the membrane reaches a
//  programmable threshold, the block emits a one-cycle spike, clears the membrane
//  and enters a refractory period.
// PARAMETERS
//  DATA_W       8   width of in_data (the adder sum width)
//  ACC_W        12  membrane/threshold width; must be > DATA_W
//  LEAK_SHIFT   3   leak amount = membrane >> LEAK_SHIFT (only with leak macro)
//  REFRACT_CYC  4   refractory length in clocks; legal range 1..255
// PORTS
//  clk        in   1      single clock, rising edge
//  rst_n      in   1      asynchronous, active-low reset
//  ena        in   1      active-high enable; 0 parks the block in IDLE
//  in_valid   in   1      in_data holds a valid adder sum
//  in_ready   out  1      block accepts in_data this cycle
//  in_data    in   DATA_W unsigned sample (adder sum)
//  threshold  in   ACC_W  unsigned firing threshold, sampled on every accept
//  spike      out  1      one-cycle pulse on fire
//  membrane   out  ACC_W  current membrane value (registered)
//  busy       out  1      high while in REFRACT
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=IDLE, membrane=0, spike=0, refractory cnt=0.
//    Release is synchronous to clk.
//  - Outputs: in_ready is combinational = ena & (state==INTEG). All other outputs are registered.
//  - FSM states: IDLE, INTEG, REFRACT.
//    IDLE -> INTEG when ena=1 (next edge). Membrane is held while in IDLE.
//    INTEG -> IDLE when ena=0. Membrane is held; no sample is accepted.
//    INTEG, on accept (in_valid & in_ready):
//      nxt = sat_ACC_W(membrane - leak + in_data).
//      If nxt >= threshold: membrane<=0, spike<=1 next cycle, cnt<=REFRACT_CYC-1,
//      state<=REFRACT.
//      Otherwise: membrane<=nxt.
//    REFRACT: in_ready=0, busy=1, cnt decrements each clock. At cnt==0 the next
//      state is INTEG if ena=1, else IDLE. in_ready is therefore low for exactly
//      REFRACT_CYC cycles after the firing edge.
//  - Latency: spike is high in the cycle immediately after the accepting edge.
//    Spike is never high for two consecutive cycles.
//  - Arithmetic: in_data is zero-extended to ACC_W. Leak is applied before the add
//    and cannot underflow, since leak <= membrane.
//  - Saturation: the sum clamps at 2^ACC_W-1 and never wraps.
//  - Boundaries:
//    threshold=0 -> every accepted sample fires.
//    threshold=2^ACC_W-1 -> fires only once saturated.
//    in_valid without ready -> no state change; the upstream holds its sum.
//    ena falling during REFRACT -> the refractory count completes, then IDLE.
//    Reset mid-REFRACT or mid-accept -> immediate return to reset values;
//    any pending spike is lost.
// CONFIGURATION
//  - NEURON_SAD_LEAK_EN defined: each accept subtracts leak = membrane >> LEAK_SHIFT.
//  - NEURON_SAD_LEAK_EN undefined: leak = 0 (pure integrator). Ports are unchanged.
// STRUCTURE
//  - Package neuron_sad_pkg holds: state enum {IDLE, INTEG, REFRACT}, the DATA_W
//    and ACC_W defaults, and function sat_add(acc, leak, x).
//  - One sub-module, neuron_refract_counter: loadable down-counter with a done flag.
//  - FSM, membrane datapath and threshold compare stay in the top module.
// TESTING (defaults; leak off unless stated)
//  1. threshold=100, accept 40,40,40 -> membrane 40,80; spike=1 after 3rd accept;
//     membrane=0.
//  2. After a spike, hold in_valid=1 -> in_ready=0 for exactly 4 cycles, then 1;
//     busy mirrors the refractory window.
//  3. threshold=4095, accept 255 x16 -> membrane=4080; 17th accept saturates to
//     4095 and fires; no wrap to 239.
//  4. Leak on: membrane=64, threshold=200, accept 10 -> membrane=66 (64-8+10).
//  5. Assert rst_n=0 during REFRACT cnt=2 -> same-cycle async clear;
//     after release state=IDLE, in_ready=0 until ena seen.
//  6. threshold=0, ena toggled 1->0 mid-stream -> each accept fires; with ena=0,
//     in_ready=0 and membrane is held.

Source files
------------

// File: rtl/neuron_sad_pkg.sv
// -----------------------------------------------------------------------------
// neuron_sad_pkg
// Shared definitions for the leaky integrate-and-fire stage that sits behind
// the 8-bit Sklansky adder.
//   - state_t     : FSM encoding (IDLE, INTEG, REFRACT)
//   - DATA_W_DEF  : default sample width (adder sum width)
//   - ACC_W_DEF   : default membrane / threshold width
//   - sat_add()   : membrane - leak + sample, clamped to 2^acc_w-1
// -----------------------------------------------------------------------------
package neuron_sad_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    INTEG   = 2'd1,
    REFRACT = 2'd2
  } state_t;

  localparam int DATA_W_DEF = 8;
  localparam int ACC_W_DEF  = 12;

  // Working width of sat_add. Operands are zero-extended to this width so the
  // helper serves any ACC_W up to 31 bits.
  localparam int SAT_W = 32;

  // The caller guarantees leak <= acc, so the subtraction never underflows.
  // One guard bit above SAT_W catches the carry before the clamp.
  function automatic logic [SAT_W-1:0] sat_add(
    input logic [SAT_W-1:0] acc,
    input logic [SAT_W-1:0] leak,
    input logic [SAT_W-1:0] x,
    input int unsigned      acc_w
  );
    logic [SAT_W:0] sum;
    logic [SAT_W:0] max_val;
    sum     = {1'b0, acc - leak} + {1'b0, x};
    max_val = ({{SAT_W{1'b0}}, 1'b1} << acc_w) - {{SAT_W{1'b0}}, 1'b1};
    if (sum > max_val) begin
      sum = max_val;
    end
    return sum[SAT_W-1:0];
  endfunction

endpackage

// File: rtl/neuron_refract_counter.sv
// -----------------------------------------------------------------------------
// neuron_refract_counter
// Loadable down-counter that times the refractory window.
// Ports:
//   clk      in   clock, rising edge
//   rst_n    in   asynchronous active-low reset (count cleared to 0)
//   load     in   load load_val this cycle (takes priority over dec)
//   dec      in   decrement by one while the count is non-zero
//   load_val in   CNT_W value to load
//   done     out  count is zero
// -----------------------------------------------------------------------------
module neuron_refract_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             dec,
  input  logic [CNT_W-1:0] load_val,
  output logic             done
);

  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (load) begin
      cnt_reg <= load_val;
    end else if (dec && (cnt_reg != '0)) begin
      cnt_reg <= cnt_reg - 1'b1;
    end
  end

  assign done = (cnt_reg == '0);

endmodule

// File: rtl/neuron_sad_integrator.sv
// -----------------------------------------------------------------------------
// neuron_sad_integrator
// Leaky integrate-and-fire stage. Each accepted adder sum is added into a
// saturating membrane register; reaching the threshold emits a one-cycle
// spike, clears the membrane and starts a refractory period.
// Optional feature: define NEURON_SAD_LEAK_EN to subtract
// membrane >> LEAK_SHIFT on every accept (otherwise a pure integrator).
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   ena        in   enable; 0 parks the block in IDLE
//   in_valid   in   in_data holds a valid sample
//   in_ready   out  sample accepted this cycle (combinational)
//   in_data    in   DATA_W unsigned sample
//   threshold  in   ACC_W firing threshold, sampled on each accept
//   spike      out  one-cycle fire pulse (registered)
//   membrane   out  ACC_W membrane value (registered)
//   busy       out  high while refractory (registered)
// -----------------------------------------------------------------------------
module neuron_sad_integrator
  import neuron_sad_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int ACC_W       = ACC_W_DEF,
  parameter int LEAK_SHIFT  = 3,
  parameter int REFRACT_CYC = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [ACC_W-1:0]  threshold,
  output logic              spike,
  output logic [ACC_W-1:0]  membrane,
  output logic              busy
);

`ifdef NEURON_SAD_LEAK_EN
  localparam logic LEAK_ON = 1'b1;
`else
  localparam logic LEAK_ON = 1'b0;
`endif

  // Counter is loaded with REFRACT_CYC-1 on the firing edge and the FSM leaves
  // REFRACT on the edge where it reads zero, giving REFRACT_CYC cycles total.
  localparam logic [7:0] REFRACT_LOAD = 8'(REFRACT_CYC - 1);

  state_t            state_reg, state_next;
  logic [ACC_W-1:0]  membrane_reg;
  logic              spike_reg;
  logic              busy_reg;

  logic              accept;
  logic              fire;
  logic              cnt_load;
  logic              cnt_done;
  logic [SAT_W-1:0]  mem_ext;
  logic [SAT_W-1:0]  leak_ext;
  logic [SAT_W-1:0]  data_ext;
  logic [SAT_W-1:0]  thr_ext;
  logic [SAT_W-1:0]  nxt_full;

  assign in_ready = ena && (state_reg == INTEG);
  assign accept   = in_valid && in_ready;

  // Datapath: everything widened to SAT_W; the clamp inside sat_add keeps
  // nxt_full within ACC_W bits, so the upper bits are zero.
  assign mem_ext  = {{(SAT_W-ACC_W){1'b0}}, membrane_reg};
  assign data_ext = {{(SAT_W-DATA_W){1'b0}}, in_data};
  assign thr_ext  = {{(SAT_W-ACC_W){1'b0}}, threshold};
  assign leak_ext = LEAK_ON ? (mem_ext >> LEAK_SHIFT) : '0;
  assign nxt_full = sat_add(mem_ext, leak_ext, data_ext, unsigned'(ACC_W));
  assign fire     = accept && (nxt_full >= thr_ext);

  neuron_refract_counter #(
    .CNT_W(8)
  ) u_refract_counter (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .dec      (state_reg == REFRACT),
    .load_val (REFRACT_LOAD),
    .done     (cnt_done)
  );

  always_comb begin
    state_next = state_reg;
    cnt_load   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (ena) state_next = INTEG;
      end
      INTEG: begin
        if (!ena) begin
          state_next = IDLE;
        end else if (fire) begin
          state_next = REFRACT;
          cnt_load   = 1'b1;
        end
      end
      REFRACT: begin
        // ena only decides where we go once the window has fully elapsed.
        if (cnt_done) state_next = ena ? INTEG : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      membrane_reg <= '0;
      spike_reg    <= 1'b0;
      busy_reg     <= 1'b0;
    end else begin
      state_reg <= state_next;
      spike_reg <= fire;
      busy_reg  <= (state_next == REFRACT);
      if (accept) begin
        membrane_reg <= fire ? '0 : nxt_full[ACC_W-1:0];
      end
    end
  end

  assign spike    = spike_reg;
  assign membrane = membrane_reg;
  assign busy     = busy_reg;

endmodule

// File: tb/tb_neuron_sad_integrator.sv
module tb_neuron_sad_integrator;

  localparam int DATA_W      = 8;
  localparam int ACC_W       = 12;
  localparam int LEAK_SHIFT  = 3;
  localparam int REFRACT_CYC = 4;
  localparam int ACC_MAX     = (1 << ACC_W) - 1;

`ifdef NEURON_SAD_LEAK_EN
  localparam bit LEAK_ON = 1'b1;
`else
  localparam bit LEAK_ON = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic              ena;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [ACC_W-1:0]  threshold;
  logic              spike;
  logic [ACC_W-1:0]  membrane;
  logic              busy;

  always #5 clk = ~clk;

  neuron_sad_integrator #(
    .DATA_W      (DATA_W),
    .ACC_W       (ACC_W),
    .LEAK_SHIFT  (LEAK_SHIFT),
    .REFRACT_CYC (REFRACT_CYC)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .threshold (threshold),
    .spike     (spike),
    .membrane  (membrane),
    .busy      (busy)
  );

  typedef struct {
    logic             spk;
    logic [ACC_W-1:0] mem;
  } exp_t;

  exp_t sb_q[$];
  int   model_mem;
  int   checks   = 0;
  int   failures = 0;

  // Drives one sample and waits (bounded) for it to be accepted. On the
  // accepting edge the reference model result is pushed onto the scoreboard.
  // Entry and exit phase: 1 time unit after a rising edge.
  task automatic drive_sample(input int x, input int thr);
    int nxt;
    int leak;
    bit got;
    in_valid  = 1'b1;
    in_data   = x[DATA_W-1:0];
    threshold = thr[ACC_W-1:0];
    got       = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (in_ready) begin
        leak = LEAK_ON ? (model_mem >> LEAK_SHIFT) : 0;
        nxt  = model_mem - leak + x;
        if (nxt > ACC_MAX) nxt = ACC_MAX;
        if (nxt >= thr) begin
          sb_q.push_back('{1'b1, '0});
          model_mem = 0;
        end else begin
          sb_q.push_back('{1'b0, nxt[ACC_W-1:0]});
          model_mem = nxt;
        end
        got = 1'b1;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout: in_ready=%0b required 1 within 20 cycles", in_ready);
    end
  endtask

  task automatic apply_reset();
    rst_n    = 1'b0;
    ena      = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    threshold = '0;
    sb_q.delete();
    model_mem = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    ena = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    exp_t e;
    rst_n = 1'b0; ena = 1'b0; in_valid = 1'b0; in_data = '0; threshold = '0;
    model_mem = 0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (membrane !== '0 || spike !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_values: mem=%0d spike=%0b busy=%0b ready=%0b required 0/0/0/0",
               membrane, spike, busy, in_ready);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL idle_without_ena: in_ready=%0b required 0", in_ready);
    end
    ena = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL idle_to_integ: in_ready=%0b required 1", in_ready);
    end
    e = '{1'b0, '0};
    $display("test_reset done: mem=%0d ready=%0b", membrane, in_ready);
  endtask

  task automatic test_integrate();
    exp_t e;
    for (int k = 0; k < 3; k++) begin
      drive_sample(40, 100);
      e = sb_q.pop_front();
      checks++;
      if (spike !== e.spk || membrane !== e.mem) begin
        failures++;
        $display("FAIL integrate[%0d]: spike=%0b mem=%0d required spike=%0b mem=%0d",
                 k, spike, membrane, e.spk, e.mem);
      end
      $display("integrate[%0d]: spike=%0b mem=%0d", k, spike, membrane);
    end
  endtask

  // Called right after the firing edge; in_valid stays high throughout.
  task automatic test_refract_window();
    in_valid = 1'b1;
    in_data  = 8'd77;
    for (int c = 0; c < REFRACT_CYC; c++) begin
      checks++;
      if (in_ready !== 1'b0 || busy !== 1'b1 || membrane !== '0) begin
        failures++;
        $display("FAIL refract_cycle[%0d]: ready=%0b busy=%0b mem=%0d required 0/1/0",
                 c, in_ready, busy, membrane);
      end
      if (c == 1) begin
        checks++;
        if (spike !== 1'b0) begin
          failures++;
          $display("FAIL spike_single_cycle: spike=%0b required 0", spike);
        end
      end
      $display("refract cycle %0d: ready=%0b busy=%0b", c, in_ready, busy);
      @(posedge clk); #1;
    end
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL refract_exit: ready=%0b busy=%0b required 1/0", in_ready, busy);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_saturate();
    exp_t e;
    apply_reset();
    for (int k = 0; k < 17; k++) begin
      drive_sample(255, ACC_MAX);
      e = sb_q.pop_front();
      checks++;
      if (spike !== e.spk || membrane !== e.mem) begin
        failures++;
        $display("FAIL saturate[%0d]: spike=%0b mem=%0d required spike=%0b mem=%0d",
                 k, spike, membrane, e.spk, e.mem);
      end
`ifndef NEURON_SAD_LEAK_EN
      if (k == 15) begin
        checks++;
        if (membrane !== 12'd4080) begin
          failures++;
          $display("FAIL saturate_16: mem=%0d required 4080", membrane);
        end
      end
      if (k == 16) begin
        checks++;
        if (spike !== 1'b1 || membrane !== 12'd0) begin
          failures++;
          $display("FAIL saturate_fire: spike=%0b mem=%0d required 1/0", spike, membrane);
        end
      end
`endif
      $display("saturate[%0d]: spike=%0b mem=%0d", k, spike, membrane);
    end
  endtask

  task automatic test_leak();
    exp_t e;
    apply_reset();
    drive_sample(64, 200);
    e = sb_q.pop_front();
    checks++;
    if (spike !== e.spk || membrane !== e.mem) begin
      failures++;
      $display("FAIL leak_load: spike=%0b mem=%0d required spike=%0b mem=%0d",
               spike, membrane, e.spk, e.mem);
    end
    drive_sample(10, 200);
    e = sb_q.pop_front();
    checks++;
    if (spike !== e.spk || membrane !== e.mem) begin
      failures++;
      $display("FAIL leak_step: spike=%0b mem=%0d required spike=%0b mem=%0d",
               spike, membrane, e.spk, e.mem);
    end
    checks++;
`ifdef NEURON_SAD_LEAK_EN
    if (membrane !== 12'd66) begin
      failures++;
      $display("FAIL leak_value: mem=%0d required 66", membrane);
    end
`else
    if (membrane !== 12'd74) begin
      failures++;
      $display("FAIL noleak_value: mem=%0d required 74", membrane);
    end
`endif
    $display("leak: mem=%0d", membrane);
  endtask

  task automatic test_reset_mid_refract();
    exp_t e;
    apply_reset();
    drive_sample(1, 0);
    e = sb_q.pop_front();
    checks++;
    if (spike !== e.spk || membrane !== e.mem) begin
      failures++;
      $display("FAIL prefire: spike=%0b mem=%0d required spike=%0b mem=%0d",
               spike, membrane, e.spk, e.mem);
    end
    @(posedge clk); #1;          // count now 2
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL refract_before_reset: busy=%0b required 1", busy);
    end
    rst_n = 1'b0;
    ena   = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || spike !== 1'b0 || membrane !== '0 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL async_clear: busy=%0b spike=%0b mem=%0d ready=%0b required 0/0/0/0",
               busy, spike, membrane, in_ready);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_mem = 0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL post_reset_idle: ready=%0b busy=%0b required 0/0", in_ready, busy);
    end
    ena = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL post_reset_ena: ready=%0b required 1", in_ready);
    end
    $display("reset_mid_refract: ready=%0b busy=%0b", in_ready, busy);
  endtask

  task automatic test_thresh_zero_ena();
    exp_t e;
    apply_reset();
    for (int k = 0; k < 2; k++) begin
      drive_sample(5 + 4 * k, 0);
      e = sb_q.pop_front();
      checks++;
      if (spike !== e.spk || membrane !== e.mem) begin
        failures++;
        $display("FAIL thr0[%0d]: spike=%0b mem=%0d required spike=%0b mem=%0d",
                 k, spike, membrane, e.spk, e.mem);
      end
      $display("thr0[%0d]: spike=%0b mem=%0d", k, spike, membrane);
    end
    // ena drops during REFRACT: window completes, then IDLE.
    ena = 1'b0;
    repeat (REFRACT_CYC + 2) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL ena_low_after_refract: busy=%0b ready=%0b required 0/0", busy, in_ready);
    end
    ena = 1'b1;
    @(posedge clk); #1;
    drive_sample(30, ACC_MAX);
    e = sb_q.pop_front();
    checks++;
    if (spike !== e.spk || membrane !== e.mem) begin
      failures++;
      $display("FAIL pre_hold: spike=%0b mem=%0d required spike=%0b mem=%0d",
               spike, membrane, e.spk, e.mem);
    end
    ena      = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'd99;
    threshold = '0;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (in_ready !== 1'b0 || membrane !== 12'd30 || spike !== 1'b0) begin
        failures++;
        $display("FAIL ena_low_hold[%0d]: ready=%0b mem=%0d spike=%0b required 0/30/0",
                 c, in_ready, membrane, spike);
      end
      $display("ena_low_hold[%0d]: ready=%0b mem=%0d", c, in_ready, membrane);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    ena = 1'b1;
    @(posedge clk); #1;
    drive_sample(1, 0);
    e = sb_q.pop_front();
    checks++;
    if (spike !== e.spk || membrane !== e.mem) begin
      failures++;
      $display("FAIL thr0_resume: spike=%0b mem=%0d required spike=%0b mem=%0d",
               spike, membrane, e.spk, e.mem);
    end
    $display("thr0_resume: spike=%0b mem=%0d", spike, membrane);
  endtask

  initial begin
    test_reset();
    test_integrate();
    test_refract_window();
    test_saturate();
    test_leak();
    test_reset_mid_refract();
    test_thresh_zero_ena();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
